// File: rtl/ap_ctrl_perf_monitor.sv
// Per-channel performance monitor for HLS ap_ctrl handshakes.
// Counts activity, records latency statistics, and serves them through a registered read port.
module ap_ctrl_perf_monitor #(
    parameter int unsigned NUM_CH = 5,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned LAT_W  = 16,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              finish,
    input  logic              clear,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic [NUM_CH-1:0] overflow
);

    typedef enum logic [1:0] {StIdle, StBusy, StDoneWait} state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic              frozen_q;
    logic [CNT_W-1:0]  start_cnt [NUM_CH];
    logic [CNT_W-1:0]  done_cnt  [NUM_CH];
    logic [CNT_W-1:0]  busy_cyc  [NUM_CH];
    logic [CNT_W-1:0]  stall_cyc [NUM_CH];
    logic [CNT_W-1:0]  idle_cyc  [NUM_CH];
    logic [LAT_W-1:0]  last_lat  [NUM_CH];
    logic [LAT_W-1:0]  min_lat   [NUM_CH];
    logic [LAT_W-1:0]  max_lat   [NUM_CH];
    logic [NUM_CH-1:0] ovf_w;

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            frozen_q <= 1'b0;
        end else if (finish) begin
            frozen_q <= 1'b1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e           state_q, state_d;
        logic [LAT_W-1:0] lat_q, lat_d, lat_inc, rec_val;
        logic [LAT_W-1:0] last_q, min_q, max_q;
        logic [CNT_W-1:0] start_q, done_q, busy_q, stall_q, idle_q;
        logic [CNT_W-1:0] start_n, done_n, busy_n, stall_n, idle_n;
        logic             rec, start_inc, busy_inc, stall_inc, idle_inc, sat_hit, ovf_q;

        always_comb begin
            lat_inc = (&lat_q) ? lat_q : lat_q + 1'b1;
            state_d = state_q;
            lat_d   = lat_q;
            rec     = 1'b0;
            rec_val = lat_q;
            unique case (state_q)
                StIdle: begin
                    if (ap_start[c]) begin
                        if (!ap_done[c]) begin
                            state_d = StBusy;
                            lat_d   = LAT_W'(1);
                        end else if (ap_continue[c]) begin
                            rec     = 1'b1;
                            rec_val = LAT_W'(1);
                        end else begin
                            state_d = StDoneWait;
                            lat_d   = LAT_W'(1);
                        end
                    end
                end
                StBusy: begin
                    lat_d = lat_inc;
                    if (ap_done[c]) begin
                        if (ap_continue[c]) begin
                            rec     = 1'b1;
                            rec_val = lat_inc;
                            if (ap_start[c]) begin
                                lat_d = LAT_W'(1);
                            end else begin
                                state_d = StIdle;
                            end
                        end else begin
                            state_d = StDoneWait;
                        end
                    end
                end
                StDoneWait: begin
                    if (ap_continue[c]) begin
                        rec     = 1'b1;
                        rec_val = lat_q;
                        if (ap_start[c]) begin
                            state_d = StBusy;
                            lat_d   = LAT_W'(1);
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase

            start_inc = ap_start[c] & ap_ready[c];
            busy_inc  = (state_q == StBusy) || ((state_q == StIdle) && ap_start[c]);
            stall_inc = (state_q == StDoneWait);
            idle_inc  = (state_q == StIdle) && !ap_start[c];
            start_n   = sat_inc(start_q);
            done_n    = sat_inc(done_q);
            busy_n    = sat_inc(busy_q);
            stall_n   = sat_inc(stall_q);
            idle_n    = sat_inc(idle_q);
            // A counter that reaches all ones through an increment marks the channel saturated.
            sat_hit   = (start_inc && (&start_n)) || (rec && (&done_n)) ||
                        (busy_inc && (&busy_n)) || (stall_inc && (&stall_n)) ||
                        (idle_inc && (&idle_n));
        end

        always_ff @(posedge clock) begin
            if (!reset || clear) begin
                state_q <= StIdle;
                lat_q   <= '0;
                last_q  <= '0;
                min_q   <= '1;
                max_q   <= '0;
                start_q <= '0;
                done_q  <= '0;
                busy_q  <= '0;
                stall_q <= '0;
                idle_q  <= '0;
                ovf_q   <= 1'b0;
            end else if (!frozen_q) begin
                state_q <= state_d;
                lat_q   <= lat_d;
                if (rec) begin
                    last_q <= rec_val;
                    min_q  <= (rec_val < min_q) ? rec_val : min_q;
                    max_q  <= (rec_val > max_q) ? rec_val : max_q;
                    done_q <= done_n;
                end
                if (start_inc) start_q <= start_n;
                if (busy_inc)  busy_q  <= busy_n;
                if (stall_inc) stall_q <= stall_n;
                if (idle_inc)  idle_q  <= idle_n;
                if (sat_hit)   ovf_q   <= 1'b1;
            end
        end

        assign start_cnt[c] = start_q;
        assign done_cnt[c]  = done_q;
        assign busy_cyc[c]  = busy_q;
        assign stall_cyc[c] = stall_q;
        assign idle_cyc[c]  = idle_q;
        assign last_lat[c]  = last_q;
        assign min_lat[c]   = min_q;
        assign max_lat[c]   = max_q;
        assign ovf_w[c]     = ovf_q;
    end

    logic [CNT_W-1:0] rd_mux;
    logic [CNT_W-1:0] rd_data_q;
    logic             rd_valid_q;

    always_comb begin
        rd_mux = '0;
        if (32'(rd_ch) < NUM_CH) begin
            case (rd_sel)
                3'd0:    rd_mux = start_cnt[rd_ch];
                3'd1:    rd_mux = done_cnt[rd_ch];
                3'd2:    rd_mux = busy_cyc[rd_ch];
                3'd3:    rd_mux = stall_cyc[rd_ch];
                3'd4:    rd_mux = idle_cyc[rd_ch];
                3'd5:    rd_mux = CNT_W'(last_lat[rd_ch]);
                3'd6:    rd_mux = CNT_W'(min_lat[rd_ch]);
                default: rd_mux = CNT_W'(max_lat[rd_ch]);
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= rd_mux;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign overflow = ovf_w;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Directed bench for ap_ctrl_perf_monitor: default instance plus a 4-bit counter instance
// for saturation; each scenario freezes the counters with finish before reading them out.
module tb_ap_ctrl_perf_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  ap_start, ap_ready, ap_done, ap_continue;
    logic        finish, clear, rd_en;
    logic [2:0]  rd_ch;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [4:0]  overflow;
    logic [3:0]  s_rd_data;
    logic        s_rd_valid;
    logic [4:0]  s_overflow;

    int n_checks = 0;
    int n_pass   = 0;
    int order [8] = '{4, 0, 1, 2, 3, 5, 6, 7};

    always #5 clock = ~clock;

    ap_ctrl_perf_monitor dut (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .clear(clear),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data),
        .rd_valid(rd_valid), .overflow(overflow)
    );

    ap_ctrl_perf_monitor #(.NUM_CH(5), .CNT_W(4), .LAT_W(4)) dut_sat (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .clear(clear),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(s_rd_data),
        .rd_valid(s_rd_valid), .overflow(s_overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0][31:0] mk(input logic [31:0] st, dn, bz, sl, id, la, mn, mx);
        logic [7:0][31:0] r;
        r[0] = st; r[1] = dn; r[2] = bz; r[3] = sl;
        r[4] = id; r[5] = la; r[6] = mn; r[7] = mx;
        return r;
    endfunction

    task automatic step();
        @(negedge clock);
    endtask

    task automatic clr();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Back-to-back reads of all eight statistics, idle_cyc first so a live channel reads clean.
    task automatic read_all(input string tag, input int ch, input logic [7:0][31:0] exp);
        for (int k = 0; k < 8; k++) begin
            rd_en  = 1'b1;
            rd_ch  = 3'(ch);
            rd_sel = 3'(order[k]);
            step();
            check_eq($sformatf("%s ch%0d sel%0d valid", tag, ch, order[k]), 32'(rd_valid), 1);
            check_eq($sformatf("%s ch%0d sel%0d", tag, ch, order[k]), rd_data, exp[order[k]]);
        end
        rd_en = 1'b0;
        step();
        check_eq($sformatf("%s ch%0d valid_drop", tag, ch), 32'(rd_valid), 0);
    endtask

    initial begin
        reset = 1'b0; ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
        finish = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_ch = '0; rd_sel = '0;
        step();
        step();
        check_eq("rst rd_valid", 32'(rd_valid), 0);
        check_eq("rst rd_data", rd_data, 0);
        check_eq("rst overflow", 32'(overflow), 0);
        reset = 1'b1;
        read_all("reset", 0, mk(0, 0, 0, 0, 0, 0, 32'hFFFF, 0));

        // Single transaction on ch1, latency 5.
        clr();
        ap_start[1] = 1'b1; ap_ready[1] = 1'b1; step();
        ap_ready[1] = 1'b0; step(); step(); step();
        ap_start[1] = 1'b0; ap_done[1] = 1'b1; finish = 1'b1; step();
        ap_done[1] = 1'b0; finish = 1'b0;
        read_all("single", 1, mk(1, 1, 5, 0, 0, 5, 5, 5));
        read_all("single", 0, mk(0, 0, 0, 0, 5, 0, 32'hFFFF, 0));

        // Stall on ch2: done at latency 3, ap_continue held low through the wait.
        clr();
        ap_start[2] = 1'b1; ap_ready[2] = 1'b1; step();
        ap_start[2] = 1'b0; ap_ready[2] = 1'b0; step();
        ap_done[2] = 1'b1; ap_continue[2] = 1'b0; step();
        repeat (4) step();
        ap_continue[2] = 1'b1; step();
        ap_done[2] = 1'b0; finish = 1'b1; step();
        finish = 1'b0;
        read_all("stall", 2, mk(1, 1, 3, 5, 1, 3, 3, 3));

        // Back-to-back on ch3: done with restart, three runs of latency 4.
        clr();
        ap_start[3] = 1'b1; ap_ready[3] = 1'b1; step();
        ap_ready[3] = 1'b0; step(); step();
        for (int r = 0; r < 2; r++) begin
            ap_done[3] = 1'b1; ap_ready[3] = 1'b1; step();
            ap_done[3] = 1'b0; ap_ready[3] = 1'b0; step(); step();
        end
        ap_done[3] = 1'b1; ap_start[3] = 1'b0; finish = 1'b1; step();
        ap_done[3] = 1'b0; finish = 1'b0;
        read_all("b2b", 3, mk(3, 3, 10, 0, 0, 4, 4, 4));
        read_all("b2b", 0, mk(0, 0, 0, 0, 10, 0, 32'hFFFF, 0));

        // Out-of-range channel reads zero with a valid strobe.
        rd_en = 1'b1; rd_ch = 3'd5; rd_sel = 3'd6; step();
        rd_en = 1'b0;
        check_eq("oor valid", 32'(rd_valid), 1);
        check_eq("oor data", rd_data, 0);

        // Freeze mid-BUSY on ch4; a later done must not register.
        clr();
        ap_start[4] = 1'b1; ap_ready[4] = 1'b1; step();
        ap_start[4] = 1'b0; ap_ready[4] = 1'b0; step();
        finish = 1'b1; step();
        finish = 1'b0; ap_done[4] = 1'b1;
        repeat (10) step();
        ap_done[4] = 1'b0;
        read_all("freeze", 4, mk(1, 0, 3, 0, 0, 0, 32'hFFFF, 0));
        read_all("freeze", 0, mk(0, 0, 0, 0, 3, 0, 32'hFFFF, 0));

        // Clear coincident with ap_done discards the completion.
        clr();
        ap_start[4] = 1'b1; step();
        ap_start[4] = 1'b0; ap_done[4] = 1'b1; clear = 1'b1; step();
        clear = 1'b0; ap_done[4] = 1'b0; finish = 1'b1; step();
        finish = 1'b0;
        read_all("clrdone", 4, mk(0, 0, 0, 0, 1, 0, 32'hFFFF, 0));
        check_eq("wide overflow", 32'(overflow), 0);

        // Saturation on the 4-bit instance: 20 idle cycles clamp at 15.
        clr();
        repeat (19) step();
        finish = 1'b1; step();
        finish = 1'b0;
        rd_en = 1'b1; rd_ch = 3'd0; rd_sel = 3'd4; step();
        rd_en = 1'b0;
        check_eq("sat idle", 32'(s_rd_data), 15);
        check_eq("sat valid", 32'(s_rd_valid), 1);
        check_eq("sat ovf0", 32'(s_overflow[0]), 1);
        repeat (3) step();
        check_eq("sat ovf0 sticky", 32'(s_overflow[0]), 1);
        clr();
        check_eq("sat ovf cleared", 32'(s_overflow), 0);
        rd_en = 1'b1; rd_ch = 3'd0; rd_sel = 3'd4; step();
        rd_en = 1'b0;
        check_eq("sat idle cleared", 32'(s_rd_data), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
